// File: rtl/imem_load_ctrl.sv
// Boot loader and port arbiter for the instruction memory: streams a length-prefixed
// little-endian image from the UART into memory at the boot PC, then hands the port to fetch.
module imem_load_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
  parameter int          DEPTH_WORDS = 16384,
  parameter int          ADDR_W      = 14,
  parameter int          CAP_WORDS   = DEPTH_WORDS - int'(BASE_ADDR >> 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              skip_load,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic [31:0]       fetch_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  output logic              fetch_grant,
  output logic              core_run,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(BASE_ADDR >> 2);
  localparam logic [31:0]       CAP       = 32'(CAP_WORDS);

  typedef enum logic [2:0] {IDLE, LEN, DATA, RUN, ERR} state_t;

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [31:0]       len;
  logic [31:0]       wdata_q;
  logic              wr_pend;
  logic              core_run_q;
  logic              load_done_q;
  logic              load_err_q;
  logic [ADDR_W:0]   wl;

  logic              xfer;
  logic              last_byte;
  logic [31:0]       byte_word;
  logic              last_write;

  assign xfer       = rx_valid & rx_ready;
  assign last_byte  = xfer && (byte_cnt == 2'd3);
  assign byte_word  = {rx_data, word_buf};
  // The write cycle carrying word number len-1 is the last one before RUN.
  assign last_write = wr_pend && (({{(31-ADDR_W){1'b0}}, wl} + 32'd1) == len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = skip_load ? RUN : LEN;
      LEN: begin
        if (last_byte) begin
          if (byte_word == 32'd0)     state_nxt = RUN;
          else if (byte_word > CAP)   state_nxt = ERR;
          else                        state_nxt = DATA;
        end
      end
      DATA:    if (last_write) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_ready     = (state == LEN) || (state == DATA);
    fetch_grant  = (state == RUN);
    imem_we      = wr_pend;
    imem_wdata   = wdata_q;
    core_run     = core_run_q;
    load_done    = load_done_q;
    load_err     = load_err_q;
    words_loaded = wl;
    imem_addr    = '0;
    if (state == RUN)  imem_addr = fetch_pc[ADDR_W+1:2];
    else if (wr_pend)  imem_addr = BASE_WORD + wl[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt    <= '0;
      word_buf    <= '0;
      len         <= '0;
      wdata_q     <= '0;
      wr_pend     <= 1'b0;
      wl          <= '0;
      core_run_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    word_buf[7:0]   <= rx_data;
          2'd1:    word_buf[15:8]  <= rx_data;
          2'd2:    word_buf[23:16] <= rx_data;
          default: ;
        endcase
      end
      if (state == LEN && last_byte) len <= byte_word;
      wr_pend <= (state == DATA) && last_byte;
      if ((state == DATA) && last_byte) wdata_q <= byte_word;
      if (wr_pend) wl <= wl + 1'b1;
      if (state_nxt == RUN) load_done_q <= 1'b1;
      if (state_nxt == ERR) load_err_q  <= 1'b1;
      if (state == RUN)     core_run_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed-plus-random bench for imem_load_ctrl; a queue of expected memory writes
// derived from each image is consumed as the DUT writes.
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        skip_load;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] fetch_pc;
  logic [13:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic        fetch_grant;
  logic        core_run;
  logic        load_done;
  logic        load_err;
  logic [14:0] words_loaded;

  imem_load_ctrl dut (
    .clk(clk), .reset(reset), .skip_load(skip_load),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .fetch_pc(fetch_pc), .imem_addr(imem_addr), .imem_we(imem_we),
    .imem_wdata(imem_wdata), .fetch_grant(fetch_grant), .core_run(core_run),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct { logic [13:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic        acc;
  logic [13:0] last_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record whether a byte transfers at the edge, then check any write.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    acc = rx_valid && rx_ready;
    @(posedge clk);
    #1;
    if (imem_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", imem_we, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", imem_addr, e.a);
        chk("wr_data", imem_wdata, e.d);
        last_addr = imem_addr;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int tries = 0;
    do begin
      rx_valid = ($urandom_range(99) >= gap_pct);
      rx_data  = rx_valid ? b : 8'($urandom);
      tick();
      tries++;
    end while (!acc && tries < 1000);
    if (!acc) chk("rx_timeout", acc, 1'b1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_pct);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_pct);
  endtask

  task automatic do_reset(input logic skip);
    reset     = 1'b0;
    rx_valid  = 1'b0;
    skip_load = skip;
    exp_q.delete();
    #3;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_grant", fetch_grant, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_words", words_loaded, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Loads img[] as a length-prefixed image and checks the hand-over to fetch.
  task automatic load_image(input int gap_pct);
    int n = img.size();
    for (int i = 0; i < n; i++) exp_q.push_back('{14'(32'h2000 + i), img[i]});
    send_word(32'(n), gap_pct);
    for (int i = 0; i < n; i++) begin
      send_word(img[i], gap_pct);
      chk("we_after_4th_byte", imem_we, 1'b1);
    end
    tick();
    tick();
    chk("writes_pending", exp_q.size(), 0);
    chk("words_loaded", words_loaded, n);
    chk("grant_after_load", fetch_grant, 1'b1);
    chk("core_run_after_load", core_run, 1'b1);
    chk("done_after_load", load_done, 1'b1);
    chk("err_after_load", load_err, 1'b0);
  endtask

  task automatic check_fetch_path();
    for (int i = 0; i < 4; i++) begin
      fetch_pc = $urandom;
      #1;
      chk("fetch_addr", imem_addr, (fetch_pc >> 2) & 32'h3FFF);
    end
  endtask

  initial begin
    reset = 1'b1; skip_load = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; fetch_pc = 32'h0;
    last_addr = '0;
    #2;

    // Skip: straight to RUN, core released on the following edge.
    do_reset(1'b1);
    chk("skip_grant", fetch_grant, 1'b1);
    chk("skip_done", load_done, 1'b1);
    chk("skip_core_run_early", core_run, 1'b0);
    tick();
    chk("skip_core_run", core_run, 1'b1);
    fetch_pc = 32'h0000_8004; #1;
    chk("skip_fetch_8004", imem_addr, 14'h2001);
    fetch_pc = 32'hFFFF_8008; #1;
    chk("fetch_upper_ignored", imem_addr, 14'h2002);
    check_fetch_path();
    for (int i = 0; i < 5; i++) tick();
    chk("skip_no_write", exp_q.size(), 0);

    // Zero-length image.
    do_reset(1'b0);
    img.delete();
    load_image(0);

    // Two-word image with gaps.
    do_reset(1'b0);
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'hDEAD_BEEF);
    load_image(40);
    chk("two_word_last_addr", last_addr, 14'h2001);
    check_fetch_path();

    // Random images with random gaps.
    for (int r = 0; r < 3; r++) begin
      do_reset(1'b0);
      img.delete();
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) img.push_back($urandom);
      load_image(30);
    end

    // Oversize length: error, port never granted, no further transfers.
    do_reset(1'b0);
    send_word(32'd8193, 20);
    chk("err_flag", load_err, 1'b1);
    chk("err_rx_ready", rx_ready, 1'b0);
    rx_valid = 1'b1; rx_data = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("err_no_accept", acc, 1'b0);
      chk("err_core_run", core_run, 1'b0);
      chk("err_grant", fetch_grant, 1'b0);
      chk("err_done", load_done, 1'b0);
    end
    rx_valid = 1'b0;

    // Reset in the middle of a load, then a fresh one-word image.
    do_reset(1'b0);
    exp_q.push_back('{14'h2000, 32'h1122_3344});
    send_word(32'd2, 0);
    send_word(32'h1122_3344, 0);
    send_byte(8'h55, 0);
    tick();
    chk("mid_words", words_loaded, 1);
    chk("mid_core_run", core_run, 1'b0);
    #2;
    do_reset(1'b0);
    chk("restart_rx_ready", rx_ready, 1'b1);
    img.delete();
    img.push_back($urandom);
    load_image(25);
    chk("restart_addr", last_addr, 14'h2000);

    // Maximum-size image.
    do_reset(1'b0);
    img.delete();
    for (int i = 0; i < 8192; i++) img.push_back($urandom);
    load_image(0);
    chk("max_last_addr", last_addr, 14'h3FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Boot-time controller and arbiter for the single-port instruction memory read by the fetch stage.
- After reset, it receives a program image as a byte stream from the UART receiver, assembles 32-bit words and writes them to instruction memory starting at the boot PC.
- Once loading finishes, it hands the memory port to fetch and releases the core.
- While a load is in progress, fetch is denied the port and the core is held.

Parameters:
- BASE_ADDR, 32'h0000_8000, byte address of the first loaded word; equals the fetch reset PC.
- DEPTH_WORDS, 16384, instruction memory depth in words.
- ADDR_W, 14, instruction memory word-address width.
- CAP_WORDS, DEPTH_WORDS-(BASE_ADDR>>2) (=8192), maximum loadable word count.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- skip_load  in  1  sampled in IDLE; when 1, go straight to RUN without loading.
- rx_valid  in  1  a byte is offered on rx_data.
- rx_data  in  8  received byte.
- rx_ready  out  1  controller accepts a byte; transfer = rx_valid & rx_ready.
- fetch_pc  in  32  byte PC requested by fetch.
- imem_addr  out  ADDR_W  instruction memory word address.
- imem_we  out  1  instruction memory write strobe.
- imem_wdata  out  32  instruction memory write data.
- fetch_grant  out  1  fetch owns the memory port.
- core_run  out  1  core released; the core's reset is qualified with this.
- load_done  out  1  sticky; load completed successfully or was skipped.
- load_err  out  1  sticky; length exceeded CAP_WORDS.
- words_loaded  out  ADDR_W+1  number of words written so far.

Behaviour:
- Reset (async, reset==0): state=IDLE. All outputs 0: rx_ready, imem_we, imem_wdata, imem_addr, fetch_grant, core_run, load_done, load_err, words_loaded. Byte counter and length register are cleared.
- Reset mid-load abandons the load immediately. Memory contents already written are left as-is.
- States: IDLE, LEN, DATA, RUN, ERR.
- IDLE: one cycle. skip_load=1 -> RUN. Otherwise -> LEN.
- LEN: rx_ready=1. Collects 4 bytes little-endian (first byte -> bits [7:0]) into len.
  - After the 4th transfer: len==0 -> RUN; len>CAP_WORDS -> ERR; otherwise -> DATA.
- DATA: rx_ready=1. Collects 4 bytes little-endian into a word buffer; the byte counter wraps 3->0.
  - On the cycle after the 4th byte transfer, imem_we=1 for exactly one cycle, with imem_addr=(BASE_ADDR>>2)+words_loaded and imem_wdata=the assembled word.
  - words_loaded increments in that same cycle.
  - When words_loaded reaches len, the next state is RUN, entered on the cycle after the final write.
- Gaps in rx_valid are allowed anywhere. Byte state is held and there is no timeout.
- A byte offered in the cycle imem_we=1 is accepted normally; the write and the byte capture do not conflict.
- RUN:
  - fetch_grant=1; load_done=1 (set on entry).
  - imem_addr=fetch_pc[ADDR_W+1:2], combinational, so fetch latency is unchanged.
  - imem_we=0; rx_ready=0.
  - core_run goes to 1 on the first clock edge in RUN and stays 1 until reset.
  - RUN is terminal until reset.
- ERR: load_err=1, rx_ready=0, core_run=0, fetch_grant=0. Terminal until reset.
- Outside RUN, imem_addr is driven only by the loader and fetch_pc is ignored.
- fetch_pc bits outside [ADDR_W+1:2] are ignored.
- imem_we never asserts in RUN, IDLE or ERR.
- rx_data is ignored when the transfer condition is false.

Test Plan:
- skip_load=1 at reset release -> IDLE, RUN; core_run=1 by the 2nd edge; load_done=1; imem_we never asserts; fetch_pc=32'h8004 drives imem_addr=14'h2001.
- Stream 00 00 00 00 -> RUN after the 4th byte; words_loaded=0; no writes.
- Stream 02 00 00 00, 13 00 00 00, EF BE AD DE with rx_valid gaps -> writes 32'h00000013 @ addr 14'h2000, then 32'hDEADBEEF @ 14'h2001; words_loaded=2; core_run=1 after the last write.
- Length 01 20 00 00 (8193) -> ERR; load_err=1; rx_ready=0; core_run stays 0; further bytes are not accepted.
- reset=0 asserted after 5 data bytes, then released with skip_load=0 -> all outputs 0, state returns to LEN, byte counter restarts; a new 1-word image is written to 14'h2000.
- Length exactly 8192 -> accepted; the last write goes to 14'h3FFF; words_loaded=8192; RUN is entered.
